// File: rtl/fifo_pack_sync_pkg.sv
// Shared definitions for the narrow-to-wide packing FIFO: beat ordering, width helper
// and the mapping from arrival order to physical lane.
package fifo_pack_sync_pkg;

   typedef enum logic {
      ORDER_LSB = 1'b0,
      ORDER_MSB = 1'b1
   } beatOrder_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Arrival lane 0 is the first beat of a word; MSB ordering mirrors it to the top slot.
   function automatic int laneSlot(input int lane, input int ratio, input beatOrder_e order);
      return (order == ORDER_MSB) ? (ratio - 1 - lane) : lane;
   endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock show-ahead FIFO; the head entry is visible combinationally whenever it holds data.
module sync_fifo_sc
   import fifo_pack_sync_pkg::*;
#(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_vld,
   output logic [clog2(DEPTH):0]      usedw,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doWrite;
   logic             doRead;

   // The pointers carry one extra wrap bit so a full buffer is distinguishable from an empty one.
   always_comb begin
      usedw   = wrPtr_q - rdPtr_q;
      full    = (usedw == (AW + 1)'(DEPTH));
      empty   = (usedw == '0);
      rd_vld  = !empty;
      rd_data = mem[rdPtr_q[AW-1:0]];
      doWrite = wr_en && !full;
      doRead  = rd_en && !empty;
      wrPtr_d = doWrite ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = doRead  ? rdPtr_q + 1'b1 : rdPtr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doWrite) begin
         mem[wrPtr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/fifo_pack_sync.sv
// Packs RATIO narrow beats into one wide word, flushes partial words on eop with a lane keep mask,
// and buffers finished words for a backpressured consumer.
module fifo_pack_sync
   import fifo_pack_sync_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int RATIO     = 4,
   parameter int DEPTH     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_W-1:0]           data_in,
   input  logic                      data_in_vld,
   input  logic                      data_in_eop,
   output logic                      data_in_rdy,
   input  logic                      b_rdy,
   output logic [IN_W*RATIO-1:0]     data_out,
   output logic                      data_out_vld,
   output logic [RATIO-1:0]          data_out_keep,
   output logic                      data_out_eop,
   output logic [clog2(DEPTH):0]     usedw,
   output logic                      full,
   output logic                      empty,
   output logic                      ovf_err
);

   localparam int         OUT_W  = IN_W * RATIO;
   localparam int         LANE_W = clog2(RATIO);
   localparam int         FIFO_W = OUT_W + RATIO + 1;
   localparam beatOrder_e ORDER  = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [OUT_W-1:0]  word_q, word_d;
   logic [RATIO-1:0]  keep_q, keep_d;
   logic              ovfErr_q, ovfErr_d;

   logic              accept;
   logic              commit;
   logic [OUT_W-1:0]  wordMerged;
   logic [RATIO-1:0]  keepMerged;
   logic [FIFO_W-1:0] fifoRdData;
   logic              fifoVld;
   logic              fifoFull;

   // Merge the incoming beat into the partial word; a commit ships the merged word and restarts at lane 0.
   always_comb begin
      accept     = data_in_vld && data_in_rdy;
      commit     = accept && ((lane_q == LAST_LANE) || data_in_eop);
      wordMerged = word_q;
      keepMerged = keep_q;
      for (int k = 0; k < RATIO; k++) begin
         if (k == laneSlot(int'(lane_q), RATIO, ORDER)) begin
            wordMerged[k*IN_W +: IN_W] = data_in;
            keepMerged[k]              = 1'b1;
         end
      end
      lane_d   = lane_q;
      word_d   = word_q;
      keep_d   = keep_q;
      ovfErr_d = ovfErr_q || (data_in_vld && !data_in_rdy);
      if (commit) begin
         lane_d = '0;
         word_d = '0;
         keep_d = '0;
      end else if (accept) begin
         lane_d = lane_q + 1'b1;
         word_d = wordMerged;
         keep_d = keepMerged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q   <= '0;
         word_q   <= '0;
         keep_q   <= '0;
         ovfErr_q <= 1'b0;
      end else begin
         lane_q   <= lane_d;
         word_q   <= word_d;
         keep_q   <= keep_d;
         ovfErr_q <= ovfErr_d;
      end
   end

   sync_fifo_sc #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) wordFifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (commit),
      .wr_data ({data_in_eop, keepMerged, wordMerged}),
      .rd_en   (data_out_vld && b_rdy),
      .rd_data (fifoRdData),
      .rd_vld  (fifoVld),
      .usedw   (usedw),
      .full    (fifoFull),
      .empty   (empty)
   );

   // Head fields are forced to zero while nothing is stored so reset leaves every output quiet.
   always_comb begin
      data_in_rdy   = !fifoFull;
      full          = fifoFull;
      ovf_err       = ovfErr_q;
      data_out_vld  = fifoVld;
      data_out      = fifoVld ? fifoRdData[OUT_W-1:0] : '0;
      data_out_keep = fifoVld ? fifoRdData[OUT_W +: RATIO] : '0;
      data_out_eop  = fifoVld ? fifoRdData[FIFO_W-1] : 1'b0;
   end

endmodule

// File: tb/tb_fifo_pack_sync.sv
// Directed plus randomized checks of fifo_pack_sync against a queue-based model of packing and buffering.
module tb_fifo_pack_sync;

   localparam int IN_W  = 8;
   localparam int RATIO = 4;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        eop;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  dataIn;
   logic        dataInVld, dataInEop, bRdy;
   logic        dataInRdy;
   logic [31:0] dataOut;
   logic        dataOutVld, dataOutEop;
   logic [3:0]  dataOutKeep;
   logic [4:0]  usedw;
   logic        full, empty, ovfErr;

   logic [7:0]  dataIn2;
   logic        dataInVld2, dataInEop2;
   logic        dataInRdy2;
   logic [31:0] dataOut2;
   logic        dataOutVld2, dataOutEop2;
   logic [3:0]  dataOutKeep2;
   logic [4:0]  usedw2;
   logic        full2, empty2, ovfErr2;

   int checks   = 0;
   int failures = 0;

   word_t      modelQ[$];
   logic [7:0] partialQ[$];
   bit         modelOvf;

   always #5 clk = ~clk;

   fifo_pack_sync #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .data_in(dataIn), .data_in_vld(dataInVld), .data_in_eop(dataInEop),
      .data_in_rdy(dataInRdy), .b_rdy(bRdy), .data_out(dataOut), .data_out_vld(dataOutVld),
      .data_out_keep(dataOutKeep), .data_out_eop(dataOutEop), .usedw(usedw), .full(full),
      .empty(empty), .ovf_err(ovfErr)
   );

   fifo_pack_sync #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(0)) dutLsb (
      .clk(clk), .rst(rst), .data_in(dataIn2), .data_in_vld(dataInVld2), .data_in_eop(dataInEop2),
      .data_in_rdy(dataInRdy2), .b_rdy(1'b0), .data_out(dataOut2), .data_out_vld(dataOutVld2),
      .data_out_keep(dataOutKeep2), .data_out_eop(dataOutEop2), .usedw(usedw2), .full(full2),
      .empty(empty2), .ovf_err(ovfErr2)
   );

   task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference behaviour: beats collect in arrival order, a word is built with shifts when it fills or eop arrives.
   task automatic modelEdge(input logic r, input logic v, input logic [7:0] d, input logic e, input logic b);
      bit    roomM;
      word_t w;
      if (r) begin
         modelQ.delete();
         partialQ.delete();
         modelOvf = 1'b0;
         return;
      end
      roomM = (modelQ.size() < DEPTH);
      if (modelQ.size() > 0 && b) void'(modelQ.pop_front());
      if (v && !roomM) modelOvf = 1'b1;
      if (v && roomM) begin
         partialQ.push_back(d);
         if (partialQ.size() == RATIO || e) begin
            w.data = '0;
            w.keep = '0;
            w.eop  = e;
            for (int i = 0; i < partialQ.size(); i++) begin
               w.data = w.data | (32'(partialQ[i]) << (IN_W * (RATIO - 1 - i)));
               w.keep = w.keep | (4'b0001 << (RATIO - 1 - i));
            end
            modelQ.push_back(w);
            partialQ.delete();
         end
      end
   endtask

   task automatic checkOutput();
      checkEq("rdy", dataInRdy, modelQ.size() < DEPTH);
      checkEq("vld", dataOutVld, modelQ.size() > 0);
      checkEq("usedw", usedw, modelQ.size());
      checkEq("full", full, modelQ.size() == DEPTH);
      checkEq("empty", empty, modelQ.size() == 0);
      checkEq("ovf_err", ovfErr, modelOvf);
      if (modelQ.size() > 0) begin
         checkEq("data_out", dataOut, modelQ[0].data);
         checkEq("keep", dataOutKeep, modelQ[0].keep);
         checkEq("eop", dataOutEop, modelQ[0].eop);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic e, input logic b);
      rst       = r;
      dataInVld = v;
      dataIn    = d;
      dataInEop = e;
      bRdy      = b;
      @(posedge clk);
      modelEdge(r, v, d, e, b);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      rst = 1'b1; dataIn = '0; dataInVld = 1'b0; dataInEop = 1'b0; bRdy = 1'b0;
      dataIn2 = '0; dataInVld2 = 1'b0; dataInEop2 = 1'b0;
      modelOvf = 1'b0;
      @(negedge clk);

      // Reset with junk on the inputs
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      checkEq("t1_vld", dataOutVld, 1'b0);
      checkEq("t1_empty", empty, 1'b1);
      checkEq("t1_rdy", dataInRdy, 1'b1);
      checkEq("t1_ovf", ovfErr, 1'b0);

      // One full word with the consumer stalled
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      checkEq("t2_data", dataOut, 32'h01020304);
      checkEq("t2_keep", dataOutKeep, 4'hF);
      checkEq("t2_eop", dataOutEop, 1'b0);
      checkEq("t2_usedw", usedw, 5'd1);

      // Fill to the brim, overflow once, then drain
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 64; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      checkEq("t3_full", full, 1'b1);
      checkEq("t3_rdy", dataInRdy, 1'b0);
      checkEq("t3_ovf_before", ovfErr, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      checkEq("t3_ovf_after", ovfErr, 1'b1);
      checkEq("t3_head", dataOut, 32'h01020304);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkEq("t3_last", dataOut, 32'h3D3E3F40);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkEq("t3_empty", empty, 1'b1);

      // Streaming with the consumer always ready
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 65; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
         checkEq("t4_usedw_le1", usedw <= 5'd1, 1'b1);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkEq("t4_no_partial_out", dataOutVld, 1'b0);
      checkEq("t4_ovf", ovfErr, 1'b0);

      // Short packet flushed by eop, both beat orderings
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      dataInVld2 = 1'b1; dataIn2 = 8'hA1; dataInEop2 = 1'b0;
      applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
      dataIn2 = 8'hA2; dataInEop2 = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'hA2, 1'b1, 1'b0);
      dataInVld2 = 1'b0; dataInEop2 = 1'b0;
      checkEq("t5_msb_data", dataOut, 32'hA1A20000);
      checkEq("t5_msb_keep", dataOutKeep, 4'b1100);
      checkEq("t5_msb_eop", dataOutEop, 1'b1);
      checkEq("t5_lsb_vld", dataOutVld2, 1'b1);
      checkEq("t5_lsb_data", dataOut2, 32'h0000A2A1);
      checkEq("t5_lsb_keep", dataOutKeep2, 4'b0011);
      checkEq("t5_lsb_eop", dataOutEop2, 1'b1);

      // Reset with stored words and a partial word pending
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
      checkEq("t6_stored", usedw, 5'd3);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkEq("t6_empty", empty, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      checkEq("t6_data", dataOut, 32'h11121314);
      checkEq("t6_usedw", usedw, 5'd1);

      // Randomized traffic with varying consumer pressure and rare resets
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 149) == 0),
                       ($urandom_range(0, 3) != 0),
                       8'($urandom),
                       ($urandom_range(0, 6) == 0),
                       (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
